// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants, the default NOP word and the fetch FSM state enum.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH} fetch_state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: flags a load-use hazard between the lw in EX and the word in decode.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [5:0] ex_op_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] dec_rs_i,
    input  logic [4:0] dec_rt_i,
    output logic       hazard_o
);
    assign hazard_o = (ex_op_i == OP_LW) && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == dec_rs_i) || (ex_rt_i == dec_rt_i));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS fetch with redirect flush and a 3-deep instruction pipe.
// Define LOAD_USE_STALL_EN to add the one-cycle load-use stall.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] ex_inst,
    output logic [31:0] mem_inst,
    output logic [31:0] dec_pc,
    output logic        stall
);
    fetch_state_e state_q;
    logic [31:0] pc_q, target_q, inst_q, ex_q, mem_q, dec_pc_q;

`ifdef LOAD_USE_STALL_EN
    logic hazard;
    hazard_detect u_hazard (
        .ex_op_i  (ex_q[31:26]),
        .ex_rt_i  (ex_q[20:16]),
        .dec_rs_i (inst_q[25:21]),
        .dec_rt_i (inst_q[20:16]),
        .hazard_o (hazard)
    );
    assign stall = hazard & ~redirect;
`else
    assign stall = 1'b0;
`endif

    assign imem_req    = state_q != S_BOOT;
    assign imem_addr   = pc_q;
    assign instruction = inst_q;
    assign ex_inst     = ex_q;
    assign mem_inst    = mem_q;
    assign dec_pc      = dec_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            inst_q   <= NOP;
            ex_q     <= NOP;
            mem_q    <= NOP;
            dec_pc_q <= 32'h0;
        end else begin
            ex_q  <= stall ? NOP : inst_q;
            mem_q <= ex_q;
            case (state_q)
                S_BOOT: begin
                    inst_q  <= NOP;
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (redirect) begin
                        inst_q <= NOP;
                        if (imem_valid) begin
                            pc_q <= redirect_pc;
                        end else begin
                            target_q <= redirect_pc;
                            state_q  <= S_FLUSH;
                        end
                    end else if (!stall) begin
                        inst_q <= imem_valid ? imem_rdata : NOP;
                        if (imem_valid) begin
                            dec_pc_q <= pc_q;
                            pc_q     <= pc_q + 32'd4;
                        end
                    end
                end
                S_FLUSH: begin
                    // pc_q keeps the stale address so the in-flight request completes and is dropped
                    inst_q <= NOP;
                    if (imem_valid) begin
                        pc_q    <= redirect ? redirect_pc : target_q;
                        state_q <= S_FETCH;
                    end else if (redirect) begin
                        target_q <= redirect_pc;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage, expectations hand-computed.
module tb_fetch_stage;
    localparam logic [31:0] NOPW  = 32'h0000_0001;
    localparam logic [31:0] LW_T1 = 32'h8C09_0000;
    localparam logic [31:0] ADD_R = 32'h0120_5020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instruction, ex_inst, mem_inst, dec_pc;
    logic        stall;
    logic        rd_addr = 1'b1;
    logic [31:0] rdata_v = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;

    fetch_stage #(.RESET_PC(32'h0), .NOP(NOPW)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .ex_inst     (ex_inst),
        .mem_inst    (mem_inst),
        .dec_pc      (dec_pc),
        .stall       (stall)
    );

    always #5 clk = ~clk;
    assign imem_rdata = rd_addr ? imem_addr : rdata_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_inst", instruction, NOPW);
        chk("rst_ex", ex_inst, NOPW);
        chk("rst_mem", mem_inst, NOPW);
        chk("rst_dpc", dec_pc, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        imem_valid = 1'b1;
        step();
        chk("boot_req", 32'(imem_req), 32'd1);
        chk("seq_a0", imem_addr, 32'h0);
        chk("seq_inop", instruction, NOPW);
        step();
        chk("seq_a4", imem_addr, 32'h4);
        chk("seq_i0", instruction, 32'h0);
        chk("seq_dpc0", dec_pc, 32'h0);
        step();
        chk("seq_a8", imem_addr, 32'h8);
        chk("seq_i4", instruction, 32'h4);
        chk("seq_ex0", ex_inst, 32'h0);
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", imem_addr, 32'h8);
            chk("wait_inst", instruction, NOPW);
        end
        imem_valid = 1'b1;
        step();
        chk("wait_i8", instruction, 32'h8);
        chk("wait_dpc8", dec_pc, 32'h8);
        chk("wait_aC", imem_addr, 32'hC);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        chk("rdv_nostall", 32'(stall), 32'd0);
        step();
        redirect = 1'b0;
        chk("rdv_addr", imem_addr, 32'h100);
        chk("rdv_drop", instruction, NOPW);
        chk("rdv_dpc", dec_pc, 32'h8);
        step();
        chk("rdv_i100", instruction, 32'h100);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h200;
        imem_valid = 1'b0;
        step();
        redirect = 1'b0;
        chk("fl_addr", imem_addr, 32'h40);
        chk("fl_req", 32'(imem_req), 32'd1);
        chk("fl_inst", instruction, NOPW);
        step();
        chk("fl_hold", imem_addr, 32'h40);
        imem_valid = 1'b1;
        step();
        chk("fl_a200", imem_addr, 32'h200);
        chk("fl_drop", instruction, NOPW);
        step();
        chk("fl_i200", instruction, 32'h200);
        imem_valid = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        imem_valid = 1'b1;
        step();
        chk("ovr_addr", imem_addr, 32'h400);
        chk("ovr_inst", instruction, NOPW);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_a0", imem_addr, 32'h0);
        chk("wrap_inst", instruction, 32'hFFFF_FFFC);
        chk("wrap_dpc", dec_pc, 32'hFFFF_FFFC);
        rd_addr = 1'b0;
        rdata_v = LW_T1;
        step();
        rdata_v = ADD_R;
        step();
        chk("lu_ex_lw", ex_inst, LW_T1);
        chk("lu_dec_add", instruction, ADD_R);
        rdata_v = 32'h0000_1111;
`ifdef LOAD_USE_STALL_EN
        chk("lu_stall", 32'(stall), 32'd1);
        step();
        chk("lu_unstall", 32'(stall), 32'd0);
        chk("lu_bubble", ex_inst, NOPW);
        chk("lu_hold", instruction, ADD_R);
        chk("lu_hold_a", imem_addr, 32'h8);
        chk("lu_hold_dpc", dec_pc, 32'h4);
        chk("lu_mem", mem_inst, LW_T1);
        step();
        chk("lu_reenter", ex_inst, ADD_R);
        chk("lu_next", instruction, 32'h0000_1111);
        chk("lu_next_a", imem_addr, 32'hC);
`else
        chk("lu_nostall", 32'(stall), 32'd0);
        step();
        chk("lu_ex_add", ex_inst, ADD_R);
        chk("lu_next", instruction, 32'h0000_1111);
        chk("lu_next_a", imem_addr, 32'hC);
        chk("lu_mem", mem_inst, LW_T1);
`endif
        rd_addr = 1'b1;
        imem_valid = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h500;
        step();
        redirect = 1'b0;
        rst = 1'b1;
        step();
        chk("rfl_req", 32'(imem_req), 32'd0);
        chk("rfl_inst", instruction, NOPW);
        chk("rfl_dpc", dec_pc, 32'h0);
        rst = 1'b0;
        step();
        chk("rfl_addr", imem_addr, 32'h0);
        imem_valid = 1'b1;
        step();
        chk("rfl_first", instruction, 32'h0);
        chk("rfl_a4", imem_addr, 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP, default 32'h0000_0000, meaning the bubble word injected into pipeline slots.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-007 SHALL have port imem_valid  in  1  imem_rdata valid; completes the outstanding request.
REQ-008 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-009 SHALL have port redirect  in  1  resolved taken branch, jump or jr from downstream.
REQ-010 SHALL have port redirect_pc  in  32  new fetch address, valid while redirect=1.
REQ-011 SHALL have port instruction  out  32  decode-slot word, fed to the control unit.
REQ-012 SHALL have port ex_inst  out  32  word one stage back, fed to control for forwarding.
REQ-013 SHALL have port mem_inst  out  32  word two stages back, fed to control for forwarding.
REQ-014 SHALL have port dec_pc  out  32  address of the word in instruction.
REQ-015 SHALL have port stall  out  1  load-use bubble is being inserted this cycle.

Function
REQ-016 SHALL implement FSM states S_BOOT, S_FETCH, S_FLUSH.
REQ-017 S_BOOT: imem_req=0; SHALL go to S_FETCH on the next cycle.
REQ-018 S_FETCH: imem_req=1, imem_addr=pc; imem_addr SHALL stay stable until imem_valid=1.
REQ-019 In S_FETCH, imem_valid=1 with no redirect and no stall: rdata SHALL be loaded into instruction, dec_pc SHALL take pc, and pc SHALL become pc+4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0). Latency: 1 cycle from imem_valid.
REQ-020 In S_FETCH, imem_valid=0: instruction SHALL become NOP; pc SHALL hold.
REQ-021 Every non-stall cycle SHALL shift the pipe: ex_inst<=instruction and mem_inst<=ex_inst.
REQ-022 redirect=1 and imem_valid=1 in the same cycle: rdata SHALL be dropped, pc<=redirect_pc, instruction<=NOP, state SHALL stay S_FETCH.
REQ-023 redirect=1 in S_FETCH with imem_valid=0: redirect_pc SHALL be saved, instruction<=NOP, and the FSM SHALL enter S_FLUSH.
REQ-024 S_FLUSH: imem_req and the old address SHALL be held; the next imem_valid response SHALL be discarded; pc<=saved target; then return to S_FETCH.
REQ-025 A second redirect in S_FLUSH SHALL overwrite the saved target.
REQ-026 redirect SHALL take priority over stall.
REQ-027 Load-use hazard: ex_inst[31:26]=6'b100011 and ex_inst[20:16]!=0 and it equals instruction[25:21] or instruction[20:16].
REQ-028 On a load-use hazard: stall=1; instruction, dec_pc and pc SHALL hold; ex_inst<=NOP; mem_inst<=ex_inst; any imem_valid that cycle SHALL be ignored, and the request re-issued at the same address.
REQ-029 The stall SHALL last exactly one cycle per hazard.

Reset
REQ-030 With rst=1 at a clock edge: pc=RESET_PC, state=S_BOOT, instruction=ex_inst=mem_inst=NOP, dec_pc=0, stall=0, imem_req=0. These values SHALL hold while rst is high.
REQ-031 rst during S_FLUSH or an outstanding request SHALL abandon it; the first response after reset SHALL come from the RESET_PC request.

Configuration
REQ-032 Macro LOAD_USE_STALL_EN: when defined, REQ-027..029 SHALL be active.
REQ-033 Without LOAD_USE_STALL_EN: stall SHALL be tied 0, there SHALL be no hazard logic, and software SHALL insert NOPs after lw.

Structure
REQ-034 The shared package mips_pkg SHALL hold the opcode/funct constants (LW=6'b100011 etc.), the NOP word, and the FSM state enum.
REQ-035 The sub-module hazard_detect (combinational, REQ-027) SHALL be instantiated only under LOAD_USE_STALL_EN.

Verification
REQ-036 Reset, then imem_valid=1 every cycle with rdata=addr: imem_addr sequence 0,4,8; instruction=0,4,8 one cycle behind.
REQ-037 imem_valid held 0 for 3 cycles at addr 8: imem_addr stays 8, instruction=NOP for 3 cycles, then 8.
REQ-038 redirect=1 with redirect_pc=32'h100 in the same cycle as imem_valid: that rdata is never visible; next imem_addr=32'h100.
REQ-039 redirect=1 with redirect_pc=32'h200 while waiting at 32'h40: imem_addr stays 32'h40 until valid; that data is discarded; next imem_addr=32'h200.
REQ-040 ex_inst=lw $t1 (rt=9), instruction=add rs=9: stall=1 for one cycle, ex_inst=NOP next cycle, and the add re-enters ex_inst the following cycle. Without the macro: no stall.
REQ-041 pc=32'hFFFF_FFFC accepted: next imem_addr=0.
